// File: rtl/jk_bank_ctrl_if.sv
// rtl/jk_bank_ctrl_if.sv - requester command bus for jk_bank_ctrl
//
// Groups the per-requester command handshake into one bundle.
//   req_valid [NREQ]       : command valid, one bit per requester
//   req_ready [NREQ]       : grant back to the requesters (at most one high)
//   req_j     [NREQ]       : J input per requester
//   req_k     [NREQ]       : K input per requester
//   req_idx   [NREQ*IDXW]  : target cell, requester r uses [r*IDXW +: IDXW]
// master modport: requester side; slave modport: controller side.

interface jk_bank_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_j;
  logic [NREQ-1:0]      req_k;
  logic [NREQ*IDXW-1:0] req_idx;

  modport master (
    output req_valid,
    output req_j,
    output req_k,
    output req_idx,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_j,
    input  req_k,
    input  req_idx,
    output req_ready
  );

endinterface

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - round-robin arbitrated command controller for a JK flip-flop bank
//
// Requesters post J/K commands for one cell of an NBITS-wide JK bank. One
// winner is granted round-robin, its command is latched, and it is applied
// after the next prescaler tick (a clock enable in the clk domain).
//
// Optional feature macro: JK_BANK_TICK_EN
//   defined   : DIV_BITS-bit free-running prescaler drives tick
//   undefined : no prescaler, tick is high whenever out of reset
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   req    slave modport of jk_bank_ctrl_if (valid/ready/j/k/idx per requester)
//   q      out  bank state [NBITS]
//   q_bar  out  bitwise inverse of q
//   busy   out  high while a command is in flight (state not IDLE)
//   tick   out  one-cycle prescaler pulse

module jk_bank_ctrl #(
  parameter int NREQ     = 4,
  parameter int NBITS    = 8,
  parameter int IDXW     = 3,
  parameter int DIV_BITS = 25
) (
  input  logic             clk,
  input  logic             reset,
  jk_bank_ctrl_if.slave    req,
  output logic [NBITS-1:0] q,
  output logic [NBITS-1:0] q_bar,
  output logic             busy,
  output logic             tick
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    APPLY     = 2'd2
  } state_t;

  state_t            state;
  logic [PTRW-1:0]   ptr;
  logic [PTRW-1:0]   lat_win;
  logic              lat_j;
  logic              lat_k;
  logic [IDXW-1:0]   lat_idx;

  logic              win_any;
  logic [PTRW-1:0]   win_idx;
  logic [PTRW-1:0]   cand;
  logic              win_j;
  logic              win_k;
  logic [IDXW-1:0]   win_cell;
  logic [PTRW-1:0]   ptr_next;
  logic [NBITS-1:0]  next_q;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PTRW'((int'(ptr) + i) % NREQ);
      if (!win_any && req.req_valid[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Mux out the winner's command fields.
  always_comb begin
    win_j    = 1'b0;
    win_k    = 1'b0;
    win_cell = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (PTRW'(r) == win_idx) begin
        win_j    = req.req_j[r];
        win_k    = req.req_k[r];
        win_cell = req.req_idx[r*IDXW +: IDXW];
      end
    end
  end

  // Grant is combinational and only offered in IDLE; held low during reset.
  assign req.req_ready = (reset && (state == IDLE) && win_any)
                         ? (NREQ'(1) << win_idx) : '0;

  // Cell update: an index outside the bank matches no cell, so the
  // command is consumed with no visible effect.
  always_comb begin
    next_q = q;
    for (int b = 0; b < NBITS; b++) begin
      if (lat_idx == IDXW'(b)) begin
        unique case ({lat_j, lat_k})
          2'b00:   next_q[b] = q[b];
          2'b01:   next_q[b] = 1'b0;
          2'b10:   next_q[b] = 1'b1;
          default: next_q[b] = ~q[b];
        endcase
      end
    end
  end

  assign ptr_next = PTRW'((int'(lat_win) + 1) % NREQ);
  assign q_bar    = ~q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      q       <= '0;
      busy    <= 1'b0;
      lat_win <= '0;
      lat_j   <= 1'b0;
      lat_k   <= 1'b0;
      lat_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_any) begin
            lat_win <= win_idx;
            lat_j   <= win_j;
            lat_k   <= win_k;
            lat_idx <= win_cell;
            state   <= WAIT_TICK;
            busy    <= 1'b1;
          end
        end
        // Only a tick seen here counts; ticks in IDLE/APPLY are not stored.
        WAIT_TICK: begin
          if (tick) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          q     <= next_q;
          ptr   <= ptr_next;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef JK_BANK_TICK_EN
  logic [DIV_BITS-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_BITS'(1);
    end
  end

  // Counter is cleared in reset, so tick is naturally low there.
  assign tick = &div_cnt;
`else
  // No prescaler: tick is a constant enable outside reset. A zero-width
  // DIV_BITS is a broken configuration and keeps tick low.
  assign tick = reset & (DIV_BITS > 0);
`endif

endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Arbitrated command controller for a bank of JK flip-flop cells. Up to `NREQ` requesters issue J/K commands addressed to one bit of an `NBITS`-wide JK register bank. The block grants requesters round-robin, latches the winning command, and applies it on the next slow-clock tick from a built-in prescaler. The tick uses a clock enable in the `clk` domain, replacing a divided clock. The bank state is driven out as `q`/`q_bar`.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `NBITS`, 8: JK cells in the bank.
- `IDXW`, 3: index width; must satisfy 2^IDXW >= NBITS.
- `DIV_BITS`, 25: prescaler width; tick period is 2^DIV_BITS cycles.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester command valid.
- `req_ready`  out  NREQ  per-requester grant; combinational, at most one bit high.
- `req_j`  in  NREQ  J input per requester.
- `req_k`  in  NREQ  K input per requester.
- `req_idx`  in  NREQ*IDXW  target cell per requester; requester r uses bits [r*IDXW +: IDXW].
- `q`  out  NBITS  bank state.
- `q_bar`  out  NBITS  always bitwise ~q.
- `busy`  out  1  high when the state is not IDLE.
- `tick`  out  1  one-cycle prescaler pulse.

## Operation
- Reset (`reset`=0):
  - `q`=0 and `q_bar`=all ones.
  - State IDLE; round-robin pointer `ptr`=0.
  - Prescaler counter=0.
  - `busy`=0, `req_ready`=0, `tick`=0.
  - Any latched command is discarded and never applied.
- FSM: IDLE -> WAIT_TICK -> APPLY -> IDLE.
- IDLE:
  - If any `req_valid` is high, the winner is the first valid requester searching ptr, ptr+1, ... NREQ-1, 0, ... (modulo NREQ).
  - `req_ready[winner]`=1 in the same cycle.
  - On the clock edge, the winner's J, K and idx and the winner index are latched; the state moves to WAIT_TICK.
  - If no request is valid, the FSM stays in IDLE and `req_ready`=0.
- WAIT_TICK: `req_ready`=0. When `tick`=1 the state moves to APPLY; otherwise it stays.
- APPLY: on the edge leaving APPLY:
  - The latched cell is updated: JK=00 hold, 01 clear, 10 set, 11 toggle.
  - `ptr` <= winner+1 (modulo NREQ).
  - State returns to IDLE.
- Only the addressed cell changes. If idx >= NBITS, the command is consumed, no cell changes, and `ptr` still advances.
- Requesters must hold valid/J/K/idx stable until granted. Dropping `req_valid` before a grant withdraws the request.
- Prescaler:
  - Free-running DIV_BITS-bit counter that wraps from all ones to 0.
  - `tick`=1 in the cycle where counter == all ones.
  - It runs regardless of FSM state.

## Timing
- Accept handshake at edge E0: `req_valid` & `req_ready` are both high before E0.
- With the prescaler enabled:
  - `q` changes at the first edge after the first tick cycle that follows E0, plus one edge (WAIT_TICK->APPLY, APPLY->IDLE).
  - Worst-case latency is 2^DIV_BITS+1 cycles.
- With the prescaler disabled, `q` changes at edge E0+2.
- Peak throughput is one command per 3 cycles. The next grant is possible in the cycle after APPLY.
- A tick that occurs while the FSM is in IDLE or APPLY is not stored; WAIT_TICK waits for the next tick.
- A request arriving while `busy`=1 waits; it is not queued internally.
- If reset asserts mid-operation, all state clears immediately (asynchronously). Operation resumes from IDLE with `ptr`=0 on the first edge after reset deasserts.

## Configuration
- `JK_BANK_TICK_EN` defined:
  - The prescaler is instantiated.
  - Commands are applied only after a tick, as described above.
- `JK_BANK_TICK_EN` undefined:
  - No prescaler counter is built.
  - `tick` is tied to 1, so WAIT_TICK always lasts exactly one cycle and latency is fixed at E0+2.
  - `DIV_BITS` is unused.

## Test plan
- Reset: drive `reset`=0 mid-run -> `q`=8'h00, `q_bar`=8'hFF, `busy`=0, `req_ready`=0 immediately, asynchronously.
- Single toggle (macro off): requester 2, JK=11, idx=5, from reset -> `q`=8'h20 at E0+2; repeat the command -> `q`=8'h00.
- Round-robin: all 4 requesters held valid with JK=10 and distinct idx 0..3 -> grants issued in order 0,1,2,3,0. Then requester 1 only is valid while ptr=2 -> requester 1 is granted next.
- Out-of-range index: idx=7 with NBITS=6, JK=10 -> grant occurs, `q` unchanged, next grant goes to the following requester.
- Tick gating (macro on, DIV_BITS=3): accept at cycle 1 -> `q` updates exactly one edge after the cycle-7 tick. `tick` pulses at cycles 7, 15, 23 after reset.
- Reset in WAIT_TICK: accept JK=10 idx=0, then pulse `reset` before the tick -> `q` stays 0, `busy`=0, and the next grant goes to requester 0.
